// File: rtl/pc_stack_unit.sv
// Program counter with a LIFO return-address stack and a sticky error flag.
// Optional interrupt entry is compiled in with the PC_INTR_EN macro.
module pc_stack_unit #(
    parameter int              AW       = 10,
    parameter int              DEPTH    = 8,
    parameter logic [AW-1:0]   INTR_VEC = {AW{1'b1}}
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PC_LD,
    input  logic          PC_INC,
    input  logic [1:0]    PC_MUX_SEL,
    input  logic [AW-1:0] IR,
    input  logic [AW-1:0] SCR_DATA_OUT,
    input  logic          CALL,
    input  logic          RET,
    input  logic          INTR,
    output logic [AW-1:0] PC_COUNT,
    output logic          STK_FULL,
    output logic          STK_EMPTY,
    output logic          STK_ERR
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            IW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] wr_idx;
    logic [AW-1:0] top;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] mux_val;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] push_val;
    logic          push_req;
    logic          pop_req;
    logic          err_set;
    logic          intr_take;

`ifdef PC_INTR_EN
    assign intr_take = INTR;
`else
    logic unused_intr;
    assign unused_intr = INTR;
    assign intr_take   = 1'b0;
`endif

    assign STK_FULL  = (cnt == DEPTH_C);
    assign STK_EMPTY = (cnt == '0);
    assign top_idx   = IW'(cnt - 1'b1);
    assign wr_idx    = IW'(cnt);
    // An empty stack reads as address 0 so underflow and peek-on-empty both load 0.
    assign top       = STK_EMPTY ? '0 : mem[top_idx];
    assign pc_plus1  = PC_COUNT + 1'b1;

    always_comb begin
        case (PC_MUX_SEL)
            2'd0:    mux_val = IR;
            2'd1:    mux_val = SCR_DATA_OUT;
            2'd2:    mux_val = top;
            default: mux_val = INTR_VEC;
        endcase
    end

    always_comb begin
        pc_next  = PC_COUNT;
        push_req = 1'b0;
        pop_req  = 1'b0;
        push_val = pc_plus1;
        err_set  = 1'b0;
        if (intr_take) begin
            pc_next  = INTR_VEC;
            push_req = 1'b1;
            push_val = PC_COUNT;
        end else if (PC_LD) begin
            pc_next = mux_val;
            if (CALL && RET) begin
                err_set = 1'b1;
            end else if (CALL) begin
                push_req = 1'b1;
            end else if (RET && (PC_MUX_SEL == 2'd2)) begin
                pop_req = 1'b1;
            end
        end else if (PC_INC) begin
            pc_next = pc_plus1;
        end
        if ((push_req && STK_FULL) || (pop_req && STK_EMPTY)) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC_COUNT <= '0;
            cnt      <= '0;
            STK_ERR  <= 1'b0;
        end else begin
            PC_COUNT <= pc_next;
            STK_ERR  <= STK_ERR | err_set;
            if (push_req && !STK_FULL) begin
                cnt <= cnt + 1'b1;
            end else if (pop_req && !STK_EMPTY) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Entry storage needs no reset: entries above the count are never read.
    always_ff @(posedge CLK) begin
        if (!RST && push_req && !STK_FULL) begin
            mem[wr_idx] <= push_val;
        end
    end
endmodule
